// File: rtl/ddr2_clk_rst_sequencer_0.sv
// ddr2_clk_rst_sequencer_0
// Brings up the DDR2 memory clock and controller reset after the clock
// manager locks. The sequence is: filter lock, hold the controller reset with
// the memory clock running, wait for the memory clock to be stable, then
// report init_ready. Losing lock from RST_HOLD onward restarts the sequence.
//
// Optional feature: define DDR2_LOCK_LOSS_STATUS_EN to build the sticky
// lock_lost flag and the saturating lock_loss_cnt. Without it both outputs
// are tied to zero and sequencing is unchanged.
//
// Handshake note: this block has no valid/ready interfaces. dcm_locked is a
// level input that is asynchronous to clk. All outputs are plain registered
// levels that are updated on every clk edge.
module ddr2_clk_rst_sequencer_0 #(
    parameter int unsigned LOCK_FILTER     = 8,
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned STABLE_CYCLES   = 40000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dcm_locked,
    output logic       ck_en,
    output logic       rst_out,
    output logic       init_ready,
    output logic       lock_lost,
    output logic [3:0] lock_loss_cnt
);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        FILTER    = 3'd1,
        RST_HOLD  = 3'd2,
        CK_STABLE = 3'd3,
        READY     = 3'd4
    } state_t;

    localparam logic [15:0] FILTER_LOAD = 16'(LOCK_FILTER - 1);
    localparam logic [15:0] HOLD_LOAD   = 16'(RST_HOLD_CYCLES - 1);
    localparam logic [15:0] STABLE_LOAD = 16'(STABLE_CYCLES - 1);

    // State is kept as a named signal so that checkers can bind to it.
    state_t      state;
    logic [15:0] cnt;
    logic        sync_0;
    logic        lk;

    // Two-flop synchronizer for the asynchronous lock input
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_0 <= 1'b0;
            lk     <= 1'b0;
        end else begin
            sync_0 <= dcm_locked;
            lk     <= sync_0;
        end
    end

    // Sequencer FSM. The outputs are registered from the current state, so
    // they follow a state change by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_LOCK;
            cnt        <= 16'd0;
            ck_en      <= 1'b0;
            rst_out    <= 1'b1;
            init_ready <= 1'b0;
        end else begin
            ck_en      <= (state == RST_HOLD) || (state == CK_STABLE) || (state == READY);
            rst_out    <= (state == WAIT_LOCK) || (state == FILTER) || (state == RST_HOLD);
            init_ready <= (state == READY);

            case (state)
                WAIT_LOCK: begin
                    if (lk) begin
                        state <= FILTER;
                        cnt   <= FILTER_LOAD;
                    end
                end
                FILTER: begin
                    if (!lk) begin
                        state <= WAIT_LOCK;
                        cnt   <= 16'd0;
                    end else if (cnt == 16'd0) begin
                        state <= RST_HOLD;
                        cnt   <= HOLD_LOAD;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                RST_HOLD: begin
                    // A lock loss takes priority over counter expiry.
                    if (!lk) begin
                        state <= WAIT_LOCK;
                        cnt   <= 16'd0;
                    end else if (cnt == 16'd0) begin
                        state <= CK_STABLE;
                        cnt   <= STABLE_LOAD;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                CK_STABLE: begin
                    if (!lk) begin
                        state <= WAIT_LOCK;
                        cnt   <= 16'd0;
                    end else if (cnt == 16'd0) begin
                        state <= READY;
                        cnt   <= 16'd0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                READY: begin
                    if (!lk) begin
                        state <= WAIT_LOCK;
                        cnt   <= 16'd0;
                    end
                end
                default: begin
                    state <= WAIT_LOCK;
                    cnt   <= 16'd0;
                end
            endcase
        end
    end

`ifdef DDR2_LOCK_LOSS_STATUS_EN
    // A loss is lock dropping once the memory clock has been enabled.
    logic loss_evt;
    assign loss_evt = !lk && ((state == RST_HOLD) || (state == CK_STABLE) || (state == READY));

    // Sticky loss flag and saturating loss counter, cleared only by rst
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_lost     <= 1'b0;
            lock_loss_cnt <= 4'd0;
        end else if (loss_evt) begin
            lock_lost <= 1'b1;
            if (lock_loss_cnt != 4'd15) begin
                lock_loss_cnt <= lock_loss_cnt + 4'd1;
            end
        end
    end
`else
    assign lock_lost     = 1'b0;
    assign lock_loss_cnt = 4'd0;
`endif

endmodule

// File: tb/tb_ddr2_clk_rst_sequencer_0.sv
// Bench for ddr2_clk_rst_sequencer_0 (LOCK_FILTER=4, RST_HOLD_CYCLES=8,
// STABLE_CYCLES=20). The reference model tracks how many consecutive edges
// the synchronized lock has been high and derives the phase from that count.
// Build with +define+DDR2_LOCK_LOSS_STATUS_EN to check the loss-status outputs.
module tb_ddr2_clk_rst_sequencer_0;

    localparam int LF  = 4;
    localparam int RH  = 8;
    localparam int ST  = 20;
    localparam int CAP = LF + RH + ST + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dcm_locked = 1'b0;
    logic       ck_en;
    logic       rst_out;
    logic       init_ready;
    logic       lock_lost;
    logic [3:0] lock_loss_cnt;

    int total = 0;
    int bad   = 0;

    ddr2_clk_rst_sequencer_0 #(
        .LOCK_FILTER(LF),
        .RST_HOLD_CYCLES(RH),
        .STABLE_CYCLES(ST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dcm_locked(dcm_locked),
        .ck_en(ck_en),
        .rst_out(rst_out),
        .init_ready(init_ready),
        .lock_lost(lock_lost),
        .lock_loss_cnt(lock_loss_cnt)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // k = consecutive edges the synchronized lock has been seen high.
    // phase: 0 wait, 1..LF filter, then hold, then stable, then ready.
    int         k = 0;
    logic       m_s1 = 1'b0;
    logic       m_s2 = 1'b0;
    logic       exp_ck = 1'b0;
    logic       exp_ro = 1'b1;
    logic       exp_ir = 1'b0;
    logic       exp_lost = 1'b0;
    logic [3:0] exp_cnt = 4'd0;
    logic [7:0] obs;
    logic [7:0] exp_vec;

    assign obs     = {ck_en, rst_out, init_ready, lock_lost, lock_loss_cnt};
    assign exp_vec = {exp_ck, exp_ro, exp_ir, exp_lost, exp_cnt};

    always @(posedge clk) begin
        if (rst) begin
            k = 0; m_s1 = 1'b0; m_s2 = 1'b0;
            exp_ck = 1'b0; exp_ro = 1'b1; exp_ir = 1'b0;
            exp_lost = 1'b0; exp_cnt = 4'd0;
        end else begin
            exp_ck = (k > LF);
            exp_ro = (k <= LF + RH);
            exp_ir = (k > LF + RH + ST);
`ifdef DDR2_LOCK_LOSS_STATUS_EN
            if (!m_s2 && k > LF) begin
                exp_lost = 1'b1;
                if (exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
            end
`endif
            if (m_s2) k = (k + 1 > CAP) ? CAP : k + 1;
            else      k = 0;
            m_s2 = m_s1;
            m_s1 = dcm_locked;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        dcm_locked = 1'b0;
        apply_reset();
        total++;
        if (obs !== 8'b0100_0000) begin
            bad++;
            $display("FAIL reset_values got=%b want=%b", obs, 8'b0100_0000);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, obs, exp_vec);
            end
        end
    endtask

    task automatic test_full_sequence();
        int ck_rise = -1;
        int ro_fall = -1;
        int ir_rise = -1;
        apply_reset();
        dcm_locked = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int c = 1; c <= 45; c++) begin
            step();
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL full_seq cyc=%0d got=%b want=%b", c, obs, exp_vec);
            end
            if (ck_en && ck_rise < 0) ck_rise = c;
            if (!rst_out && ro_fall < 0) ro_fall = c;
            if (init_ready && ir_rise < 0) ir_rise = c;
        end
        total++;
        if (ck_rise != 2 + LF + 1) begin
            bad++;
            $display("FAIL ck_en_rise got=%0d want=%0d", ck_rise, 2 + LF + 1);
        end
        total++;
        if (ro_fall != 2 + LF + 1 + RH) begin
            bad++;
            $display("FAIL rst_out_fall got=%0d want=%0d", ro_fall, 2 + LF + 1 + RH);
        end
        total++;
        if (ir_rise != 2 + LF + 1 + RH + ST) begin
            bad++;
            $display("FAIL init_ready_rise got=%0d want=%0d", ir_rise, 2 + LF + 1 + RH + ST);
        end
    endtask

    task automatic test_short_pulse();
        apply_reset();
        dcm_locked = 1'b1;
        for (int i = 0; i < 3; i++) step();
        dcm_locked = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL short_pulse cyc=%0d got=%b want=%b", i, obs, exp_vec);
            end
        end
        total++;
        if (ck_en !== 1'b0 || lock_loss_cnt !== 4'd0) begin
            bad++;
            $display("FAIL short_pulse_end ck_en=%b cnt=%0d want ck_en=0 cnt=0", ck_en, lock_loss_cnt);
        end
    endtask

    task automatic test_loss_in_stable();
        int guard = 0;
        int lat = -1;
        apply_reset();
        dcm_locked = 1'b1;
        while (rst_out && guard < 100) begin
            step();
            guard++;
        end
        total++;
        if (rst_out) begin
            bad++;
            $display("FAIL stable_wait timeout rst_out=%b want=0", rst_out);
        end
        // rst_out falls one cycle after CK_STABLE entry
        for (int i = 0; i < 9; i++) step();
        dcm_locked = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL loss_stable cyc=%0d got=%b want=%b", i, obs, exp_vec);
            end
            if (!ck_en && rst_out && lat < 0) lat = i;
        end
        total++;
        if (lat < 1 || lat > 4) begin
            bad++;
            $display("FAIL loss_latency got=%0d want=1..4", lat);
        end
        total++;
`ifdef DDR2_LOCK_LOSS_STATUS_EN
        if (lock_lost !== 1'b1 || lock_loss_cnt !== 4'd1) begin
            bad++;
            $display("FAIL loss_status got=%b/%0d want=1/1", lock_lost, lock_loss_cnt);
        end
`else
        if (lock_lost !== 1'b0 || lock_loss_cnt !== 4'd0) begin
            bad++;
            $display("FAIL loss_status got=%b/%0d want=0/0", lock_lost, lock_loss_cnt);
        end
`endif
        dcm_locked = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL relock cyc=%0d got=%b want=%b", i, obs, exp_vec);
            end
        end
        total++;
        if (init_ready !== 1'b1) begin
            bad++;
            $display("FAIL relock_ready got=%b want=1", init_ready);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int n = 0; n < 17; n++) begin
            int guard = 0;
            dcm_locked = 1'b1;
            while (!init_ready && guard < 100) begin
                step();
                guard++;
                total++;
                if (obs !== exp_vec) begin
                    bad++;
                    $display("FAIL sat_seq n=%0d got=%b want=%b", n, obs, exp_vec);
                end
            end
            total++;
            if (!init_ready) begin
                bad++;
                $display("FAIL sat_ready_timeout n=%0d init_ready=%b want=1", n, init_ready);
            end
            dcm_locked = 1'b0;
            for (int i = 0; i < 4; i++) step();
        end
        total++;
`ifdef DDR2_LOCK_LOSS_STATUS_EN
        if (lock_loss_cnt !== 4'd15 || lock_lost !== 1'b1) begin
            bad++;
            $display("FAIL sat_count got=%0d/%b want=15/1", lock_loss_cnt, lock_lost);
        end
`else
        if (lock_loss_cnt !== 4'd0 || lock_lost !== 1'b0) begin
            bad++;
            $display("FAIL sat_count got=%0d/%b want=0/0", lock_loss_cnt, lock_lost);
        end
`endif
    endtask

    task automatic test_rst_in_ready();
        apply_reset();
        dcm_locked = 1'b1;
        for (int i = 0; i < 40; i++) step();
        total++;
        if (init_ready !== 1'b1) begin
            bad++;
            $display("FAIL pre_rst_ready got=%b want=1", init_ready);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (obs !== 8'b0100_0000) begin
            bad++;
            $display("FAIL rst_in_ready got=%b want=%b", obs, 8'b0100_0000);
        end
        for (int i = 0; i < 40; i++) begin
            step();
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL rst_restart cyc=%0d got=%b want=%b", i, obs, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 29) == 0) dcm_locked = ~dcm_locked;
            rst = ($urandom_range(0, 299) == 0);
            step();
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b want=%b", i, obs, exp_vec);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_full_sequence();
        test_short_pulse();
        test_loss_in_stable();
        test_saturation();
        test_rst_in_ready();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr2_clk_rst_sequencer_0.md
DDR2_CLK_RST_SEQUENCER_0 -- requirements
Module: ddr2_clk_rst_sequencer_0

Interface
REQ-001 SHALL have parameter LOCK_FILTER, default 8: consecutive cycles dcm_locked must be high before sequencing starts (1..65535).
REQ-002 SHALL have parameter RST_HOLD_CYCLES, default 16: cycles the controller reset is held with the memory clock running (1..65535).
REQ-003 SHALL have parameter STABLE_CYCLES, default 40000: cycles of stable memory clock before init_ready (200 us at 200 MHz; 1..65535).
REQ-004 SHALL have port clk  input  1  controller clock; same clock that drives the memory-clock ODDR stage.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port dcm_locked  input  1  clock-manager lock, asynchronous to clk.
REQ-007 SHALL have port ck_en  output  1  enable for the memory-clock ODDR CE pins.
REQ-008 SHALL have port rst_out  output  1  active-high controller reset.
REQ-009 SHALL have port init_ready  output  1  memory clock stable; DDR2 init may start.
REQ-010 SHALL have port lock_lost  output  1  sticky flag: lock dropped after sequencing began.
REQ-011 SHALL have port lock_loss_cnt  output  4  saturating count of lock-loss events.

Function
REQ-012 SHALL pass dcm_locked through a 2-flop synchronizer; all decisions use the synchronized value (lk).
REQ-013 SHALL implement states WAIT_LOCK, FILTER, RST_HOLD, CK_STABLE, READY with one 16-bit down-counter reloaded on every state entry.
REQ-014 SHALL move WAIT_LOCK->FILTER on the first cycle lk=1, loading LOCK_FILTER-1.
REQ-015 SHALL move FILTER->RST_HOLD when the counter is 0 and lk=1, so FILTER lasts exactly LOCK_FILTER cycles; lk=0 in FILTER returns to WAIT_LOCK without counting a loss.
REQ-016 SHALL move RST_HOLD->CK_STABLE after exactly RST_HOLD_CYCLES cycles, and CK_STABLE->READY after exactly STABLE_CYCLES cycles.
REQ-017 SHALL remain in READY until lk=0 or rst.
REQ-018 SHALL drive registered outputs per state: WAIT_LOCK/FILTER ck_en=0 rst_out=1 init_ready=0; RST_HOLD ck_en=1 rst_out=1 init_ready=0; CK_STABLE ck_en=1 rst_out=0 init_ready=0; READY ck_en=1 rst_out=0 init_ready=1.
REQ-019 SHALL apply outputs one cycle after the state change, with no combinational path from dcm_locked to any output.
REQ-020 SHALL treat lk=0 in RST_HOLD, CK_STABLE or READY as a lock loss: go to WAIT_LOCK next cycle; outputs take WAIT_LOCK values the cycle after.
REQ-021 SHALL give lock loss priority over counter expiry in the same cycle.
REQ-022 SHALL restart the full sequence (FILTER onward) after any lock loss.

Reset
REQ-023 SHALL, on rst=1 at a clk edge, enter WAIT_LOCK, clear the counter and synchronizer flops, and drive ck_en=0, rst_out=1, init_ready=0, lock_lost=0, lock_loss_cnt=0.
REQ-024 SHALL let rst override every other event, including mid-sequence and simultaneous lock loss; a loss coincident with rst is not counted.

Configuration
REQ-025 SHALL, with macro DDR2_LOCK_LOSS_STATUS_EN defined, set lock_lost on each REQ-020 event (cleared only by rst) and increment lock_loss_cnt per event, saturating at 15.
REQ-026 SHALL, without DDR2_LOCK_LOSS_STATUS_EN, tie lock_lost and lock_loss_cnt to 0 and omit their logic; sequencing is unchanged.

Verification (LOCK_FILTER=4, RST_HOLD_CYCLES=8, STABLE_CYCLES=20)
REQ-027 SHALL cover: rst released, dcm_locked=1 held -> ck_en rises 2+4+1 cycles after lock, rst_out falls 8 cycles later, init_ready rises 20 cycles after that.
REQ-028 SHALL cover: dcm_locked pulses high 3 cycles then low -> ck_en stays 0, lock_loss_cnt stays 0.
REQ-029 SHALL cover: lock dropped at cycle 10 of CK_STABLE (macro on) -> ck_en=0, rst_out=1 within 4 cycles; lock_lost=1, lock_loss_cnt=1; relock repeats the full sequence.
REQ-030 SHALL cover: 17 lock losses from READY (macro on) -> lock_loss_cnt saturates at 15.
REQ-031 SHALL cover: rst asserted in READY with dcm_locked=1 -> next cycle all outputs at reset values, then sequence restarts.
REQ-032 SHALL cover: macro off, lock loss in READY -> lock_lost=0, lock_loss_cnt=0, sequencing identical to REQ-029.
